// File: rtl/iq_frame_serializer_pkg.sv
// Shared types and defaults for the I/Q frame serializer.
// The state encoding, symbol layout and default frame parameters live here.
package iq_frame_serializer_pkg;

  localparam int unsigned DEF_DATA_W = 14;
  localparam logic [1:0]  DEF_SYNC_I = 2'b10;
  localparam logic [1:0]  DEF_SYNC_Q = 2'b01;
  localparam logic [1:0]  DEF_IDLE   = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISYNC = 3'd1,
    ST_IDATA = 3'd2,
    ST_QSYNC = 3'd3,
    ST_QDATA = 3'd4
  } state_e;

  // d0 is driven in the clk-high phase, d1 in the clk-low phase
  typedef struct packed {
    logic d0;
    logic d1;
  } sym_t;

endpackage

// File: rtl/iq_frame_serializer_dedff.sv
// Double-edge output cell: captures a 2-bit symbol each posedge and presents
// d0 while clk is high and d1 while clk is low.
module iq_frame_serializer_dedff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d0,
  input  logic i_d1,
  output logic o_q
);

  logic r_q0;
  logic r_q1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q0 <= 1'b0;
      r_q1 <= 1'b0;
    end else begin
      r_q0 <= i_d0;
      r_q1 <= i_d1;
    end
  end

  assign o_q = i_clk ? r_q0 : r_q1;

endmodule

// File: rtl/iq_frame_serializer.sv
// Framed I/Q serializer: one-entry holding buffer, sync/data framing FSM and a
// double-edge output cell producing a 2x-rate differential serial stream.
module iq_frame_serializer
  import iq_frame_serializer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter logic [1:0]  SYNC_I = DEF_SYNC_I,
  parameter logic [1:0]  SYNC_Q = DEF_SYNC_Q,
  parameter logic [1:0]  IDLE   = DEF_IDLE
) (
  input  logic              clk,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_i,
  input  logic [DATA_W-1:0] s_q,
  input  logic              iq_only,
  output logic              serial,
  output logic              serial_N,
  output logic              serial_clk,
  output logic              frame_done,
  output logic              underflow
);

  localparam int unsigned      HALF     = DATA_W / 2;
  localparam int unsigned      CNT_W    = $clog2(HALF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  state_e              r_state;
  state_e              w_state_nx;
  state_e              w_end_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nx;
  logic [DATA_W-1:0]   r_hold_i;
  logic [DATA_W-1:0]   r_hold_q;
  logic [DATA_W-1:0]   r_sh_i;
  logic [DATA_W-1:0]   r_sh_q;
  logic [DATA_W-1:0]   w_sh_i_nx;
  logic [DATA_W-1:0]   w_sh_q_nx;
  sym_t                r_sym;
  sym_t                w_sym_nx;
  logic                r_hold_full;
  logic                w_hold_full_nx;
  logic                r_s_ready;
  logic                r_iq_only_l;
  logic                r_frame_done;
  logic                r_underflow;
  logic                w_accept;
  logic                w_last;
  logic                w_load;
  logic                w_frame_end;
  logic                w_stay;
  logic                w_done_nx;
  logic                w_serial;

  assign w_accept       = s_valid & r_s_ready;
  assign w_last         = (r_cnt == CNT_LAST);
  assign w_end_state    = r_hold_full ? ST_ISYNC : ST_IDLE;
  assign w_hold_full_nx = (r_hold_full & ~w_load) | w_accept;

  // Frame sequencing
  always_comb begin
    w_state_nx  = r_state;
    w_frame_end = 1'b0;
    case (r_state)
      ST_IDLE:  if (r_hold_full) w_state_nx = ST_ISYNC;
      ST_ISYNC: w_state_nx = ST_IDATA;
      ST_IDATA: begin
        if (w_last) begin
          w_frame_end = r_iq_only_l;
          w_state_nx  = r_iq_only_l ? w_end_state : ST_QSYNC;
        end
      end
      ST_QSYNC: w_state_nx = ST_QDATA;
      ST_QDATA: begin
        if (w_last) begin
          w_frame_end = 1'b1;
          w_state_nx  = w_end_state;
        end
      end
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  // Symbol, shift register and counter follow the state being entered
  always_comb begin
    w_sym_nx  = sym_t'(IDLE);
    w_sh_i_nx = r_sh_i;
    w_sh_q_nx = r_sh_q;
    w_cnt_nx  = '0;
    w_load    = 1'b0;
    w_stay    = (r_state == w_state_nx);
    case (w_state_nx)
      ST_ISYNC: begin
        w_load    = 1'b1;
        w_sym_nx  = sym_t'(SYNC_I);
        w_sh_i_nx = r_hold_i;
        w_sh_q_nx = r_hold_q;
      end
      ST_IDATA: begin
        w_sym_nx  = sym_t'(r_sh_i[DATA_W-1 -: 2]);
        w_sh_i_nx = {r_sh_i[DATA_W-3:0], 2'b00};
        w_cnt_nx  = w_stay ? r_cnt + CNT_W'(1) : '0;
      end
      ST_QSYNC: w_sym_nx = sym_t'(SYNC_Q);
      ST_QDATA: begin
        w_sym_nx  = sym_t'(r_sh_q[DATA_W-1 -: 2]);
        w_sh_q_nx = {r_sh_q[DATA_W-3:0], 2'b00};
        w_cnt_nx  = w_stay ? r_cnt + CNT_W'(1) : '0;
      end
      default:  w_sym_nx = sym_t'(IDLE);
    endcase
  end

  assign w_done_nx = ((w_state_nx == ST_QDATA) || ((w_state_nx == ST_IDATA) && r_iq_only_l))
                     && (w_cnt_nx == CNT_LAST);

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_hold_i     <= '0;
      r_hold_q     <= '0;
      r_sh_i       <= '0;
      r_sh_q       <= '0;
      r_sym        <= '0;
      r_hold_full  <= 1'b0;
      r_s_ready    <= 1'b0;
      r_iq_only_l  <= 1'b0;
      r_frame_done <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_sh_i       <= w_sh_i_nx;
      r_sh_q       <= w_sh_q_nx;
      r_sym        <= w_sym_nx;
      r_hold_full  <= w_hold_full_nx;
      r_s_ready    <= ~w_hold_full_nx;
      r_frame_done <= w_done_nx;
      r_underflow  <= w_frame_end & ~r_hold_full;
      if (w_load) r_iq_only_l <= iq_only;
      if (w_accept) begin
        r_hold_i <= s_i;
        r_hold_q <= s_q;
      end
    end
  end

  iq_frame_serializer_dedff u_dedff (
    .i_clk   (clk),
    .i_rst_n (start),
    .i_d0    (r_sym.d0),
    .i_d1    (r_sym.d1),
    .o_q     (w_serial)
  );

  assign serial     = w_serial;
  assign serial_N   = ~w_serial;
  assign serial_clk = clk;
  assign s_ready    = r_s_ready;
  assign frame_done = r_frame_done;
  assign underflow  = r_underflow;

endmodule
